// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared widths, iteration constants and multiplier FSM state type
package tpu_pkg;

   localparam int A_W   = 16;
   localparam int B_W   = 16;
   localparam int OUT_W = 34;

   // One RUN iteration per multiplier bit; counter wide enough to hold B_W-1
   localparam int MULT_ITERS = B_W;
   localparam int CNT_W      = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } mult_state_t;

endpackage

// File: rtl/psum_add17.sv
// rtl/psum_add17.sv - partial-sum adder: W-bit accumulator half plus multiplicand with carry-out
module psum_add17 #(
   parameter int W = 16
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W:0]   sum_o
);

   // Zero-extend both operands so the carry-out lands in the top bit
   always_comb begin
      sum_o = {1'b0, a_i} + {1'b0, b_i};
   end

endmodule

// File: rtl/shift_add_mult16.sv
// rtl/shift_add_mult16.sv - sequential shift-and-add multiplier; MULT_SIGNED_EN selects two's complement operands
module shift_add_mult16 #(
   parameter int A_W   = tpu_pkg::A_W,
   parameter int B_W   = tpu_pkg::B_W,
   parameter int OUT_W = tpu_pkg::OUT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [A_W-1:0]   a,
   input  logic [B_W-1:0]   b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] product,
   output logic             busy
);

   import tpu_pkg::*;

   localparam int P_W = A_W + B_W;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(B_W - 1);

   mult_state_t      state_q, state_d;
   logic [A_W-1:0]   mcand_q, mcand_d;
   logic [A_W-1:0]   hi_q, hi_d;
   logic [B_W-1:0]   mpl_q, mpl_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [OUT_W-1:0] product_q, product_d;
   logic             in_ready_q, out_valid_q, busy_q;

   logic [A_W:0]     psum;
   logic [A_W:0]     add_res;
   logic [P_W-1:0]   raw_prod;
   logic [OUT_W-1:0] prod_ext;
   logic [A_W-1:0]   a_load;
   logic [B_W-1:0]   b_load;

   psum_add17 #(.W(A_W)) u_psum_add17 (
      .a_i   (hi_q),
      .b_i   (mcand_q),
      .sum_o (psum)
   );

   // Final iteration result: shifted {carry, upper half, multiplier} concatenation
   always_comb begin
      add_res  = mpl_q[0] ? psum : {1'b0, hi_q};
      raw_prod = {add_res, mpl_q[B_W-1:1]};
   end

`ifdef MULT_SIGNED_EN
   logic sign_q, sign_d;
   logic [P_W-1:0] signed_res;

   // Operands are iterated as magnitudes; the sign is reapplied once at the end
   always_comb begin
      a_load     = a[A_W-1] ? (~a + 1'b1) : a;
      b_load     = b[B_W-1] ? (~b + 1'b1) : b;
      sign_d     = sign_q;
      if (in_valid && in_ready_q) begin
         sign_d = a[A_W-1] ^ b[B_W-1];
      end
      signed_res = sign_q ? (~raw_prod + 1'b1) : raw_prod;
      prod_ext   = OUT_W'($signed(signed_res));
   end

   // Sign flag register
   always_ff @(posedge clk) begin
      if (rst) begin
         sign_q <= 1'b0;
      end else begin
         sign_q <= sign_d;
      end
   end
`else
   // Unsigned operands pass straight through; product is zero-extended
   always_comb begin
      a_load   = a;
      b_load   = b;
      prod_ext = OUT_W'(raw_prod);
   end
`endif

   // FSM and datapath next-state
   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      hi_d      = hi_q;
      mpl_d     = mpl_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready_q) begin
               mcand_d = a_load;
               mpl_d   = b_load;
               hi_d    = '0;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            hi_d  = add_res[A_W:1];
            mpl_d = {add_res[0], mpl_q[B_W-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_ITER) begin
               product_d = prod_ext;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_valid_q && out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; handshake flags are registered decodes of the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         mcand_q     <= '0;
         hi_q        <= '0;
         mpl_q       <= '0;
         cnt_q       <= '0;
         product_q   <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mcand_q     <= mcand_d;
         hi_q        <= hi_d;
         mpl_q       <= mpl_d;
         cnt_q       <= cnt_d;
         product_q   <= product_d;
         in_ready_q  <= (state_d == ST_IDLE);
         out_valid_q <= (state_d == ST_DONE);
         busy_q      <= (state_d != ST_IDLE);
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign product   = product_q;

endmodule

// File: tb/tb_shift_add_mult16.sv
// tb/tb_shift_add_mult16.sv - self-checking bench for shift_add_mult16 (build with or without MULT_SIGNED_EN)
module tb_shift_add_mult16;

   import tpu_pkg::*;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [A_W-1:0]   a;
   logic [B_W-1:0]   b;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] product;
   logic             busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] va;
      logic [15:0] vb;
      logic [33:0] exp;
   } vec_t;

   vec_t vecs[$];

   logic [OUT_W-1:0] p;
   int               lat;
   logic [OUT_W-1:0] held;
   logic [OUT_W-1:0] expq[$];
   logic [15:0]      sa[4];
   logic [15:0]      sb[4];
   int               acc_n, got, cyc, last_acc, spurious;
   bit               load;

   always #5 clk = ~clk;

   shift_add_mult16 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer multiply of the operands as the build interprets them
   function automatic logic [OUT_W-1:0] model(input logic [15:0] x, input logic [15:0] y);
      longint mx, my;
`ifdef MULT_SIGNED_EN
      mx = longint'($signed(x));
      my = longint'($signed(y));
`else
      mx = longint'({48'd0, x});
      my = longint'({48'd0, y});
`endif
      return OUT_W'(mx * my);
   endfunction

   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input int hold,
                         input string tag, output logic [OUT_W-1:0] res, output int lt);
      @(negedge clk);
      check({tag, "_in_ready"}, in_ready, 1);
      a = ta; b = tb_; in_valid = 1'b1; out_ready = (hold == 0);
      @(negedge clk);
      in_valid = 1'b0;
      lt = 0;
      while (!out_valid && lt < 40) begin
         @(negedge clk);
         lt++;
      end
      check({tag, "_latency"}, lt, 16);
      res = product;
      check({tag, "_model"}, res, model(ta, tb_));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, "_hold_valid"}, out_valid, 1);
         check({tag, "_hold_product"}, product, res);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check({tag, "_valid_drop"}, out_valid, 0);
      check({tag, "_ready_back"}, in_ready, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef MULT_SIGNED_EN
      vecs.push_back('{16'hFFFF, 16'h0001, 34'h3_FFFF_FFFF});
      vecs.push_back('{16'h8000, 16'h8000, 34'h0_4000_0000});
      vecs.push_back('{16'h0064, 16'hFFFD, 34'h3_FFFF_FED4});
      vecs.push_back('{16'h0003, 16'h0005, 34'h0_0000_000F});
      vecs.push_back('{16'h0000, 16'hFFFF, 34'h0_0000_0000});
`else
      vecs.push_back('{16'h0003, 16'h0005, 34'h0_0000_000F});
      vecs.push_back('{16'hFFFF, 16'hFFFF, 34'h0_FFFE_0001});
      vecs.push_back('{16'h0000, 16'hFFFF, 34'h0_0000_0000});
      vecs.push_back('{16'h8000, 16'h0002, 34'h0_0001_0000});
      vecs.push_back('{16'hFFFF, 16'h0001, 34'h0_0000_FFFF});
`endif

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_product", product, 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", in_ready, 1);
      check("idle_busy", busy, 0);

      // Table-driven directed vectors, out_ready held high
      for (int i = 0; i < vecs.size(); i++) begin
         run_op(vecs[i].va, vecs[i].vb, 0, $sformatf("vec%0d", i), p, lat);
         check($sformatf("vec%0d_product", i), p, vecs[i].exp);
      end

      // Backpressure with stray in_valid pulses during RUN and DONE
      @(negedge clk);
      a = 16'h1234; b = 16'h0056; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      check("bp_busy_run", busy, 1);
      repeat (5) @(negedge clk);
      a = 16'd7; b = 16'd9; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("bp_valid_seen", out_valid, 1);
      held = product;
      check("bp_product", held, model(16'h1234, 16'h0056));
      a = 16'd7; b = 16'd9; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         check("bp_hold_valid", out_valid, 1);
         check("bp_hold_product", product, held);
         check("bp_hold_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release", out_valid, 0);
      spurious = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (out_valid || busy) spurious++;
      end
      check("bp_no_second_result", spurious, 0);

      // Reset in the middle of RUN
      @(negedge clk);
      a = 16'h00AB; b = 16'h00CD; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (8) @(negedge clk);
      check("mid_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_in_ready", in_ready, 0);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_product", product, 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1);
      check("post_rst_busy", busy, 0);
      run_op(16'd2, 16'd2, 0, "post_rst", p, lat);
      check("post_rst_product", p, 34'd4);

      // Random single operations with random backpressure
      for (int i = 0; i < 6; i++) begin
         run_op(16'($urandom), 16'($urandom), int'($urandom_range(0, 3)),
                $sformatf("rnd%0d", i), p, lat);
      end

      // Back-to-back stream, in_valid and out_ready held high
      for (int i = 0; i < 4; i++) begin
         sa[i] = 16'($urandom);
         sb[i] = 16'($urandom);
      end
      acc_n = 0; got = 0; cyc = 0; last_acc = -1; load = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      a = sa[0]; b = sb[0]; in_valid = 1'b1;
      while (got < 4 && cyc < 300) begin
         if (load) begin
            if (acc_n < 4) begin
               a = sa[acc_n]; b = sb[acc_n];
            end else begin
               in_valid = 1'b0;
            end
            load = 1'b0;
         end
         if (out_valid) begin
            if (expq.size() > 0) check("stream_product", product, expq.pop_front());
            else check("stream_unexpected_result", 1, 0);
            got++;
         end
         if (in_valid && in_ready) begin
            expq.push_back(model(a, b));
            if (last_acc >= 0) check("stream_accept_spacing", cyc - last_acc, 18);
            last_acc = cyc;
            acc_n++;
            load = 1'b1;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      check("stream_result_count", got, 4);
      check("stream_accept_count", acc_n, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
